// File: rtl/cust_nreg_pkg.sv
// Shared types for the custom N-bit shift register receive path.
// Latency: none (types and constant helpers only). Backpressure: n/a.
package cust_nreg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_t;

  // Bit counter must be able to hold N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cust_nreg_fifo.sv
// Synchronous word FIFO, pop-before-push when full, head word gated to 0 when empty.
// Latency: push visible on the next edge. Backpressure: push ignored when full unless popping.
module cust_nreg_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = cnt_q;
  assign dout    = empty ? '0 : mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cust_nreg_deser.sv
// MSB-first serial-to-parallel receiver with output FIFO and sticky fault flags; parity via CUST_NREG_DESER_PARITY_EN.
// Latency: word on dout the edge after its last bit. Backpressure: full FIFO drops words (overrun), no input stall.
module cust_nreg_deser
  import cust_nreg_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sin,
  input  logic                   sin_valid,
  input  logic                   start,
  output logic [N-1:0]           dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  output logic                   frame_err,
  output logic                   par_err,
  input  logic                   clr_err
);
  localparam int CW = cnt_width(N);

  deser_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [N-1:0]  word_dat;
  logic          word_done, frame_ev, ovr_ev;
  logic          ovr_q, ferr_q;
  logic          fifo_full, fifo_empty;
`ifdef CUST_NREG_DESER_PARITY_EN
  logic          par_ev, perr_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    word_done = 1'b0;
    word_dat  = sh_q;
    frame_ev  = 1'b0;
`ifdef CUST_NREG_DESER_PARITY_EN
    par_ev    = 1'b0;
`endif
    if (sin_valid) begin
      if (start) begin
        // A start always wins, even on what would have been the last bit.
        frame_ev = (state_q != IDLE);
        state_d  = SHIFT;
        cnt_d    = CW'(1);
        sh_d     = {{(N-1){1'b0}}, sin};
      end else begin
        case (state_q)
          SHIFT: begin
            sh_d = {sh_q[N-2:0], sin};
            if (cnt_q == CW'(N-1)) begin
`ifdef CUST_NREG_DESER_PARITY_EN
              state_d = PARITY;
              cnt_d   = CW'(N);
`else
              state_d   = IDLE;
              cnt_d     = '0;
              word_done = 1'b1;
              word_dat  = sh_d;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
`ifdef CUST_NREG_DESER_PARITY_EN
          PARITY: begin
            state_d = IDLE;
            cnt_d   = '0;
            if ((^sh_q) == sin) word_done = 1'b1;
            else                par_ev    = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  cust_nreg_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_done),
    .pop   (dout_ready),
    .din   (word_dat),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign dout_valid = ~fifo_empty;
  assign busy       = (state_q != IDLE);
  assign ovr_ev     = word_done & fifo_full & ~(dout_valid & dout_ready);

  // New events take priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= (ovr_q  & ~clr_err) | ovr_ev;
      ferr_q <= (ferr_q & ~clr_err) | frame_ev;
    end
  end

  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

`ifdef CUST_NREG_DESER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= (perr_q & ~clr_err) | par_ev;
  end
  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_cust_nreg_deser.sv
// Bench for cust_nreg_deser: vector table, directed corner sequences and random traffic vs a frame/queue model.
// Follows CUST_NREG_DESER_PARITY_EN the same way the design does.
module tb_cust_nreg_deser;
  localparam int N     = 8;
  localparam int DEPTH = 2;
`ifdef CUST_NREG_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = N + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0, sin_valid = 1'b0, start = 1'b0;
  logic         dout_ready = 1'b0, clr_err = 1'b0;
  logic [N-1:0] dout;
  logic         dout_valid, busy, overrun, frame_err, par_err;
  logic [1:0]   level;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: bits of the frame in progress, the FIFO as a queue, sticky flags.
  bit           in_frame = 1'b0;
  bit           mf[$];
  logic [N-1:0] mq[$];
  bit           m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;

  typedef struct {
    bit s, v, st, r;
    bit e_vld;
    logic [7:0] e_dout;
    int e_lvl;
    bit e_busy;
  } vec_t;
  vec_t tbl[$];

  cust_nreg_deser #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .start      (start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .level      (level),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .par_err    (par_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_frame = 1'b0;
    mf.delete();
    mq.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit v, input bit st, input bit r, input bit c);
    bit done = 1'b0, ov = 1'b0, fe = 1'b0, pe = 1'b0, par = 1'b0;
    bit pop = r && (mq.size() != 0);
    logic [N-1:0] w = '0;
    if (v) begin
      if (st) begin
        if (in_frame) fe = 1'b1;
        mf.delete();
        mf.push_back(s);
        in_frame = 1'b1;
      end else if (in_frame) begin
        mf.push_back(s);
        if (mf.size() == FL) begin
          for (int i = 0; i < N; i++) begin
            w   = {w[N-2:0], mf[i]};
            par = par ^ mf[i];
          end
          if (!PAR || mf[FL-1] == par) done = 1'b1;
          else                         pe   = 1'b1;
          in_frame = 1'b0;
          mf.delete();
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (done) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else                   ov = 1'b1;
    end
    m_ovr  = (m_ovr  && !c) || ov;
    m_ferr = (m_ferr && !c) || fe;
    m_perr = (m_perr && !c) || pe;
  endtask

  // Called #1 after a rising edge: drive, let one edge pass, then compare with the model.
  task automatic cycle(input bit s, input bit v, input bit st, input bit r, input bit c);
    sin = s; sin_valid = v; start = st; dout_ready = r; clr_err = c;
    @(posedge clk);
    model_step(s, v, st, r, c);
    #1;
    chk("dout_valid", dout_valid, mq.size() != 0);
    if (mq.size() != 0) chk("dout", dout, mq[0]);
    chk("level", level, mq.size());
    chk("busy", busy, in_frame);
    chk("overrun", overrun, m_ovr);
    chk("frame_err", frame_err, m_ferr);
    chk("par_err", par_err, m_perr);
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit r, input bit last_r,
                           input bit last_c, input bit bad_par);
    bit b;
    for (int i = 0; i < FL; i++) begin
      b = (i < N) ? w[N-1-i] : ((^w) ^ bad_par);
      cycle(b, 1'b1, i == 0, (i == FL-1) ? last_r : r, (i == FL-1) ? last_c : 1'b0);
    end
  endtask

  task automatic idle(input bit r, input bit c);
    cycle(1'b0, 1'b0, 1'b0, r, c);
  endtask

  initial begin
    // 8'hB2 = 1,0,1,1,0,0,1,0 with dout_ready high throughout.
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1});
`ifdef CUST_NREG_DESER_PARITY_EN
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 1, 1'b0});
`else
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 1, 1'b0});
`endif
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0});

    // Reset state.
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_flags", {overrun, frame_err, par_err}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].s, tbl[i].v, tbl[i].st, tbl[i].r, 1'b0);
      chk("tbl_vld", dout_valid, tbl[i].e_vld);
      if (tbl[i].e_vld) chk("tbl_dout", dout, tbl[i].e_dout);
      chk("tbl_level", level, tbl[i].e_lvl);
      chk("tbl_busy", busy, tbl[i].e_busy);
    end

    // Two buffered words, third overruns, then ordered drain.
    send_word(8'hA5, 0, 0, 0, 0);
    send_word(8'h3C, 0, 0, 0, 0);
    chk("b2b_level", level, 2);
    send_word(8'hFF, 0, 0, 0, 0);
    chk("ovr_set", overrun, 1);
    chk("ovr_level", level, 2);
    chk("ovr_head", dout, 8'hA5);
    idle(1, 0);
    chk("pop1_dout", dout, 8'h3C);
    chk("pop1_level", level, 1);
    idle(1, 0);
    chk("pop2_empty", dout_valid, 0);
    idle(0, 1);
    chk("ovr_clr", overrun, 0);

    // Full FIFO with a pop in the completing cycle: no overrun.
    send_word(8'hA5, 0, 0, 0, 0);
    send_word(8'h3C, 0, 0, 0, 0);
    send_word(8'hFF, 0, 1, 0, 0);
    chk("pp_no_ovr", overrun, 0);
    chk("pp_level", level, 2);
    chk("pp_head", dout, 8'h3C);
    idle(1, 0);
    chk("pp_tail", dout, 8'hFF);
    idle(1, 0);

    // Abort on the 4th bit; the restarted frame is delivered.
    cycle(1, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    send_word(8'h5A, 0, 0, 0, 0);
    chk("ferr_set", frame_err, 1);
    chk("ferr_word", dout, 8'h5A);
    chk("ferr_level", level, 1);
    idle(1, 1);
    chk("ferr_clr", frame_err, 0);

    // Start on what would have been the Nth bit is still an abort.
    for (int i = 0; i < N-1; i++) cycle(i[0], 1, i == 0, 0, 0);
    send_word(8'h81, 0, 0, 0, 0);
    chk("ferr_nth", frame_err, 1);
    chk("ferr_nth_word", dout, 8'h81);
    idle(1, 1);

    // Clear coinciding with an overrun event leaves the flag set.
    send_word(8'h11, 0, 0, 0, 0);
    send_word(8'h22, 0, 0, 0, 0);
    send_word(8'h33, 0, 0, 1, 0);
    chk("clr_vs_ev", overrun, 1);
    idle(1, 1);
    idle(1, 0);

`ifdef CUST_NREG_DESER_PARITY_EN
    send_word(8'h07, 1, 1, 0, 0);
    chk("par_ok_vld", dout_valid, 1);
    chk("par_ok_dout", dout, 8'h07);
    idle(1, 0);
    send_word(8'h07, 1, 1, 0, 1);
    chk("par_bad_vld", dout_valid, 0);
    chk("par_bad_flag", par_err, 1);
    idle(1, 1);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      bit v, st;
      v  = ($urandom_range(3) != 0);
      st = in_frame ? ($urandom_range(15) == 0) : ($urandom_range(1) == 0);
      cycle($urandom_range(1), v, st, $urandom_range(9) < 3, $urandom_range(63) == 0);
    end

    // Reset mid-frame with one word buffered and a flag set.
    idle(1, 1);
    idle(1, 1);
    send_word(8'hC3, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_vld", dout_valid, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", {overrun, frame_err, par_err}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_word(8'h96, 1, 1, 0, 0);
    chk("post_rst_vld", dout_valid, 1);
    chk("post_rst_dout", dout, 8'h96);
    idle(1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cust_nreg_deser.md
# cust_nreg_deser

Serial-to-parallel receive stage that sits directly downstream of the team's N-bit custom shift register, which emits one bit per cycle. The block assembles MSB-first serial bits into N-bit words, buffers completed words in a small FIFO, and presents them on a valid/ready interface to the consumer. Framing, overrun and (optionally) parity faults are reported through sticky flags.

## Interface
- `N`, 8: word width in bits; N >= 2.
- `DEPTH`, 2: output FIFO depth in words; a power of two, >= 2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sin`  in  1  serial data bit.
- `sin_valid`  in  1  `sin` is valid this cycle.
- `start`  in  1  frame start; qualified by `sin_valid`; marks the cycle carrying the MSB.
- `dout`  out  N  head word of the FIFO.
- `dout_valid`  out  1  FIFO not empty.
- `dout_ready`  in  1  consumer accepts `dout`.
- `busy`  out  1  a frame is in progress (not IDLE).
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overrun`  out  1  sticky: a completed word was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a frame was aborted by a new `start`.
- `par_err`  out  1  sticky: parity mismatch. Tied to 0 when parity is compiled out.
- `clr_err`  in  1  synchronous clear of all sticky flags.

## Operation
- States:
  - IDLE, SHIFT, and PARITY (PARITY only when parity is compiled in).
  - IDLE -> SHIFT on `sin_valid && start`. The bit is loaded as the MSB and the bit counter is set to 1.
  - SHIFT: each `sin_valid` shifts `sin` in at the LSB end and increments the counter. Cycles without `sin_valid` hold all state.
  - When the Nth bit is accepted: go to PARITY, or complete the word and return to IDLE.
  - PARITY: the next valid bit is the even-parity bit over the N data bits. A match completes the word. A mismatch drops the word and sets `par_err`. Either way, return to IDLE.
- `start` with `sin_valid` outside IDLE:
  - The partial frame is discarded and `frame_err` is set.
  - The new bit starts a fresh frame (counter = 1, state SHIFT).
  - A `start` bit that would have been the Nth data bit is still treated as an abort.
- `start` without `sin_valid` is ignored.
- Word completion:
  - The word is pushed if the FIFO is not full, or if it is full and a pop happens in the same cycle (pop-before-push).
  - Otherwise the word is dropped and `overrun` is set.
- Pop occurs when `dout_valid && dout_ready`. `dout` is the oldest word. The FIFO pointers wrap modulo DEPTH.
- Sticky flags:
  - `clr_err` clears all sticky flags.
  - If `clr_err` and a new error event occur in the same cycle, the flag ends set.

## Timing
- Reset values:
  - State IDLE, counter 0, shift register 0, FIFO empty.
  - `dout` = 0, `dout_valid` = 0, `busy` = 0, `level` = 0, all sticky flags 0.
- Reset mid-frame abandons the partial word and empties the FIFO immediately.
- Latency: a word whose final bit (data or parity) is accepted on edge k shows `dout_valid` = 1 and the word on `dout` after edge k. No combinational path from `sin` to `dout`.
- `dout` and `dout_valid` are registered and stable while `dout_valid && !dout_ready`.
- `dout_ready` has no combinational path to any input-side logic. It affects only the full test at push time.
- Throughput: one bit per cycle. N-cycle frames can arrive back-to-back, with `start` on the cycle after the last bit.
- `level` updates on the same edge as the push or pop. A simultaneous push and pop leaves it unchanged.

## Configuration
- `CUST_NREG_DESER_PARITY_EN` defined:
  - The PARITY state exists.
  - A frame is N+1 valid bits.
  - `par_err` is live.
- Not defined:
  - A frame is N bits and words complete straight from SHIFT.
  - `par_err` is constant 0 and no parity logic is generated.

## Structure
- Shared package `cust_nreg_pkg` holds:
  - The state enum `deser_state_t` (IDLE, SHIFT, PARITY).
  - A localparam function for the counter width, $clog2(N+1).
- One sub-module, `cust_nreg_fifo`:
  - Parameterised by width and depth.
  - Push/pop/full/empty/level signals, synchronous FIFO.
  - Uses the same `clk`/`rst` and is instantiated once.

## Test plan
- Parity out, N=8. Send 1,0,1,1,0,0,1,0 with `start` on the first bit and `dout_ready`=1 -> `dout`=8'hB2 with `dout_valid` high one cycle after the 8th bit; `level` returns to 0 next cycle.
- Back-to-back frames 8'hA5 and 8'h3C with `dout_ready`=0 -> `level`=2. A third frame 8'hFF -> dropped, `overrun`=1. Then raise `dout_ready` -> pops A5 then 3C in order.
- FIFO full and the third word completes while `dout_ready`=1 -> no overrun; A5 popped and FF pushed, `level` stays 2.
- `start` on the 4th bit of a frame -> `frame_err`=1; the following 8 bits form the delivered word; asserting `clr_err` clears the flag.
- Parity in. Send data 8'h07 with parity bit 1 -> delivered. Send 8'h07 with parity bit 0 -> not delivered, `par_err`=1.
- Assert `rst` mid-frame with the FIFO holding one word -> all outputs return to reset values immediately. The next full frame after deassertion is received correctly.
